// File: rtl/sdm_pkg.sv
// Shared constants, state type and saturating arithmetic for the second-order
// 1-bit sigma-delta modulator.
package sdm_pkg;

   localparam int unsigned SDM_DATA_W   = 20;
   localparam int unsigned SDM_OSR      = 64;
   localparam int unsigned SDM_ACC_W    = 26;
   localparam int unsigned SDM_OSR_LOG2 = $clog2(SDM_OSR);
   localparam longint      SDM_FS       = longint'(1) << (SDM_DATA_W - 1);

   typedef enum logic {
      IDLE,
      RUN
   } sdm_state_e;

   // p + q - r, clamped symmetrically to +/-(2^(acc_w-1)-1); 64 bits never overflows here
   function automatic logic signed [63:0] sat_add3(input logic signed [63:0] p,
                                                   input logic signed [63:0] q,
                                                   input logic signed [63:0] r,
                                                   input int unsigned        acc_w);
      logic signed [63:0] sum;
      logic signed [63:0] lim;
      sum = p + q - r;
      lim = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
      if (sum > lim) begin
         return lim;
      end
      if (sum < -lim) begin
         return -lim;
      end
      return sum;
   endfunction

endpackage

// File: rtl/sdm_if.sv
// Valid/ready sample handshake between the PCM source and the modulator.
interface sdm_if #(
   parameter int unsigned DATA_W = sdm_pkg::SDM_DATA_W
);

   logic signed [DATA_W-1:0] sample_in;
   logic                     sample_valid;
   logic                     sample_ready;

   modport master (
      output sample_in,
      output sample_valid,
      input  sample_ready
   );

   modport slave (
      input  sample_in,
      input  sample_valid,
      output sample_ready
   );

endinterface

// File: rtl/sdm_interpolator.sv
// One-deep sample buffer, segment phase counter, IDLE/RUN state and linear
// interpolation from anchor a to target b across OSR clocks.
module sdm_interpolator
   import sdm_pkg::*;
#(
   parameter int unsigned DATA_W = SDM_DATA_W,
   parameter int unsigned OSR    = SDM_OSR
) (
   input  logic                    clk,
   input  logic                    reset_n,
   sdm_if.slave                    smp,
   output logic signed [DATA_W:0]  x_o,
   output logic                    underrun_o
);

   localparam int unsigned LOG2 = $clog2(OSR);

   if ((OSR < 4) || ((OSR & (OSR - 1)) != 0)) begin : g_bad_osr
      $error("sdm_interpolator: OSR must be a power of two, at least 4");
   end

   sdm_state_e               state_q, state_d;
   logic [LOG2-1:0]          phase_q, phase_d;
   logic signed [DATA_W-1:0] next_q, next_d;
   logic                     next_valid_q, next_valid_d;
   logic signed [DATA_W-1:0] a_q, a_d;
   logic signed [DATA_W-1:0] b_q, b_d;
   logic signed [DATA_W:0]   x_q, x_d;
   logic                     underrun_q, underrun_d;
   logic signed [DATA_W:0]   step;
   logic                     boundary;
   logic                     accept;
   logic                     consume;

   assign smp.sample_ready = !next_valid_q;
   assign accept           = smp.sample_valid && !next_valid_q;
   assign boundary         = (phase_q == '1);
   assign consume          = boundary && next_valid_q;

   // One extra bit holds any b - a difference; >>> floors toward -inf
   assign step = ((DATA_W + 1)'(b_q) - (DATA_W + 1)'(a_q)) >>> LOG2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (consume) state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      phase_d      = phase_q + LOG2'(1);
      next_d       = next_q;
      next_valid_d = next_valid_q;
      a_d          = a_q;
      b_d          = b_q;
      x_d          = x_q + step;
      underrun_d   = 1'b0;
      // Re-anchoring x on b at every boundary discards accumulated step truncation
      if (boundary) begin
         a_d = b_q;
         x_d = (DATA_W + 1)'(b_q);
         if (next_valid_q) begin
            b_d          = next_q;
            next_valid_d = 1'b0;
         end else begin
            underrun_d = (state_q == RUN);
         end
      end
      if (accept) begin
         next_d       = smp.sample_in;
         next_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q      <= '0;
         next_q       <= '0;
         next_valid_q <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         x_q          <= '0;
         underrun_q   <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         next_q       <= next_d;
         next_valid_q <= next_valid_d;
         a_q          <= a_d;
         b_q          <= b_d;
         x_q          <= x_d;
         underrun_q   <= underrun_d;
      end
   end

   assign x_o        = x_q;
   assign underrun_o = underrun_q;

endmodule

// File: rtl/sigma_delta_modulator.sv
// Second-order 1-bit sigma-delta modulator: interpolated input feeds two
// saturating integrators and a sign quantiser producing one bit per clock.
module sigma_delta_modulator
   import sdm_pkg::*;
#(
   parameter int unsigned DATA_W = SDM_DATA_W,
   parameter int unsigned OSR    = SDM_OSR,
   parameter int unsigned ACC_W  = SDM_ACC_W
) (
   input  logic clk,
   input  logic reset_n,
   sdm_if.slave smp,
   output logic dac_out,
   output logic underrun
);

   if (ACC_W < DATA_W + 4) begin : g_bad_acc_w
      $error("sigma_delta_modulator: ACC_W must be at least DATA_W+4");
   end

   localparam logic signed [63:0] FS_W = 64'sd1 <<< (DATA_W - 1);

   logic signed [DATA_W:0]  x;
   logic signed [ACC_W-1:0] int1_q, int1_d;
   logic signed [ACC_W-1:0] int2_q, int2_d;
   logic                    dac_q, dac_d;
   logic signed [63:0]      fb;

   sdm_interpolator #(
      .DATA_W (DATA_W),
      .OSR    (OSR)
   ) u_interp (
      .clk        (clk),
      .reset_n    (reset_n),
      .smp        (smp),
      .x_o        (x),
      .underrun_o (underrun)
   );

   // int2 integrates the pre-update int1; the quantiser looks at the new int2
   always_comb begin
      fb     = dac_q ? FS_W : -FS_W;
      int1_d = ACC_W'(sat_add3(64'(int1_q), 64'(x), fb, ACC_W));
      int2_d = ACC_W'(sat_add3(64'(int2_q), 64'(int1_q), fb, ACC_W));
      dac_d  = !int2_d[ACC_W-1];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         int1_q <= '0;
         int2_q <= '0;
         dac_q  <= 1'b0;
      end else begin
         int1_q <= int1_d;
         int2_q <= int2_d;
         dac_q  <= dac_d;
      end
   end

   assign dac_out = dac_q;

endmodule

// File: tb/tb_sigma_delta_modulator.sv
// Directed bench for sigma_delta_modulator with a segment-level reference model
// compared against the DUT on every falling edge.
module tb_sigma_delta_modulator;

   localparam int     DW    = 20;
   localparam int     OSRV  = 64;
   localparam int     OSRL2 = 6;
   localparam int     ACCW  = 26;
   localparam longint FSV   = 524288;
   localparam longint LIM   = 33554431;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic dac_out;
   logic underrun;

   sdm_if #(.DATA_W(DW)) bus ();

   sigma_delta_modulator #(
      .DATA_W (DW),
      .OSR    (OSRV),
      .ACC_W  (ACCW)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .smp      (bus),
      .dac_out  (dac_out),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
      n_total++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
   endtask

   // Reference model: segment endpoints, position in segment, one-entry buffer,
   // and the two integrators written as plain clamped sums.
   int     m_phase = 0;
   longint m_a = 0, m_b = 0, m_buf = 0;
   bit     m_full = 0, m_run = 0, m_dac = 0, m_und = 0;
   longint m_int1 = 0, m_int2 = 0;
   longint acc_log[$];

   function automatic longint clampv(input longint v);
      if (v > LIM) return LIM;
      if (v < -LIM) return -LIM;
      return v;
   endfunction

   function automatic longint m_x();
      longint stp;
      stp = (m_b - m_a) >>> OSRL2;
      return m_a + longint'(m_phase) * stp;
   endfunction

   always @(posedge clk or negedge reset_n) begin : model
      longint xc, fbv, i1_old;
      bit     acc;
      if (!reset_n) begin
         m_phase = 0; m_a = 0; m_b = 0; m_buf = 0;
         m_full = 0; m_run = 0; m_dac = 0; m_und = 0;
         m_int1 = 0; m_int2 = 0;
      end else begin
         acc    = bus.sample_valid && !m_full;
         xc     = m_x();
         fbv    = m_dac ? FSV : -FSV;
         i1_old = m_int1;
         m_int1 = clampv(m_int1 + xc - fbv);
         m_int2 = clampv(m_int2 + i1_old - fbv);
         m_dac  = (m_int2 >= 0);
         if (m_phase == OSRV - 1) begin
            m_und = m_run && !m_full;
            m_a   = m_b;
            if (m_full) begin
               m_b    = m_buf;
               m_full = 0;
               m_run  = 1;
            end
            m_phase = 0;
         end else begin
            m_und = 0;
            m_phase++;
         end
         if (acc) begin
            m_full = 1;
            m_buf  = longint'(bus.sample_in);
            acc_log.push_back(m_buf);
         end
      end
   end

   always @(negedge clk) begin
      check("dac_out", longint'(dac_out), longint'(m_dac));
      check("underrun", longint'(underrun), longint'(m_und));
      check("sample_ready", longint'(bus.sample_ready), longint'(!m_full));
      check("x", longint'(dut.x), m_x());
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   bit prev_rdy;

   task automatic do_reset();
      @(negedge clk);
      #2;
      reset_n          = 1'b0;
      bus.sample_valid = 1'b0;
      bus.sample_in    = '0;
      #1;
      check("rst_dac_out", longint'(dac_out), 0);
      check("rst_underrun", longint'(underrun), 0);
      check("rst_sample_ready", longint'(bus.sample_ready), 1);
      check("rst_x", longint'(dut.x), 0);
      check("rst_int1", longint'(dut.int1_q), 0);
      check("rst_int2", longint'(dut.int2_q), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic send(input longint v);
      bus.sample_valid = 1'b1;
      bus.sample_in    = 20'(v);
      for (int i = 0; i < 2 * OSRV + 2; i++) begin
         if (bus.sample_ready) begin
            @(negedge clk);
            bus.sample_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      bus.sample_valid = 1'b0;
      check("send_timeout", 0, 1);
   endtask

   task automatic wait_phase(input int p);
      for (int i = 0; i < OSRV + 2; i++) begin
         if (m_phase == p) return;
         @(negedge clk);
      end
      check("wait_phase_timeout", 0, 1);
   endtask

   task automatic stream_cycle(input bit toggle);
      @(negedge clk);
      if (prev_rdy) begin
         if (toggle) bus.sample_in = -bus.sample_in;
         else        bus.sample_in = bus.sample_in + 20'sd1;
      end
      prev_rdy = bus.sample_ready && bus.sample_valid;
   endtask

   task automatic run_ramp(input longint target, input longint stp);
      do_reset();
      send(0);
      send(target);
      wait_phase(0);
      check("model_step", (m_b - m_a) >>> OSRL2, stp);
      for (int p = 0; p < OSRV; p++) begin
         check("interp_x", longint'(dut.x), stp * p);
         if (p == 32) check("model_x_mid", m_x(), stp * 32);
         @(negedge clk);
      end
      check("interp_end", longint'(dut.x), target);
   endtask

   task automatic density(input longint v, input longint lo, input longint hi, input string nm);
      int ones;
      do_reset();
      bus.sample_valid = 1'b1;
      bus.sample_in    = 20'(v);
      repeat (512) @(negedge clk);
      ones = 0;
      repeat (4096) begin
         @(negedge clk);
         ones += int'(dac_out);
      end
      check_range(nm, ones, lo, hi);
      bus.sample_valid = 1'b0;
   endtask

   initial begin : stim
      int     ones, und, base, n, rdy_hi;
      longint last, v1, v2, mx1, mx2;

      bus.sample_valid = 1'b0;
      bus.sample_in    = '0;

      // Idle after reset: mid-scale bitstream, no underruns
      do_reset();
      ones = 0;
      und  = 0;
      repeat (1024) begin
         @(negedge clk);
         ones += int'(dac_out);
         und  += int'(underrun);
      end
      check_range("idle_ones", ones, 508, 516);
      check("idle_underrun", und, 0);

      // DC density at +/- half scale
      density(262144, 3032, 3112, "density_pos_half");
      density(-262144, 984, 1064, "density_neg_half");

      // Interpolation ramps
      run_ramp(6400, 100);
      run_ramp(-63, -1);

      // Continuous handshake with incrementing data
      do_reset();
      bus.sample_in    = 20'sd1000;
      bus.sample_valid = 1'b1;
      prev_rdy         = bus.sample_ready;
      base             = acc_log.size();
      repeat (12 * OSRV) stream_cycle(1'b0);
      rdy_hi = 0;
      repeat (640) begin
         stream_cycle(1'b0);
         rdy_hi += int'(bus.sample_ready);
      end
      check("hs_ready_per_640", rdy_hi, 10);
      n = acc_log.size() - base;
      check_range("hs_accept_count", n, 22, 24);
      for (int i = 0; i < n; i++) check("hs_sequence", acc_log[base + i], 1000 + i);

      // Underrun: stop supply with one sample still buffered
      for (int i = 0; i < OSRV + 2; i++) begin
         stream_cycle(1'b0);
         if (m_phase == 2) break;
      end
      bus.sample_valid = 1'b0;
      last = longint'(bus.sample_in) - 1;
      und  = 0;
      repeat (320) begin
         @(negedge clk);
         und += int'(underrun);
      end
      check("underrun_pulses", und, 4);
      check("underrun_hold_x", longint'(dut.x), last);
      repeat (37) @(negedge clk);
      check("underrun_step0_x", longint'(dut.x), last);

      // Full-scale alternating stress, then reset with a sample pending
      do_reset();
      bus.sample_in    = 20'sd524287;
      bus.sample_valid = 1'b1;
      prev_rdy         = bus.sample_ready;
      mx1 = 0;
      mx2 = 0;
      repeat (2048) begin
         stream_cycle(1'b1);
         v1 = longint'(dut.int1_q);
         v2 = longint'(dut.int2_q);
         if (v1 < 0) v1 = -v1;
         if (v2 < 0) v2 = -v2;
         if (v1 > mx1) mx1 = v1;
         if (v2 > mx2) mx2 = v2;
      end
      check_range("int1_bound", mx1, 0, LIM);
      check_range("int2_bound", mx2, 0, LIM);
      for (int i = 0; i < OSRV + 2; i++) begin
         stream_cycle(1'b1);
         if (m_phase == 30) break;
      end
      check("pending_before_reset", longint'(bus.sample_ready), 0);
      do_reset();
      und = 0;
      repeat (200) begin
         @(negedge clk);
         und += int'(underrun);
      end
      check("post_reset_underrun", und, 0);
      check("post_reset_x", longint'(dut.x), 0);
      check("post_reset_ready", longint'(bus.sample_ready), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
